fmap_bank_mem: RTL and testbench
================================

# fmap_bank_mem

Banked, parametrised dual-port feature-map memory for the accelerator datapath: NUM_BANKS independent simple-dual-port banks behind one flat address space, one registered read port (A) and one write port (B). Replaces simulation-only file preload and whole-array reset with two synthesizable sequencers: a hardware clear and a streaming loader fed by the SPI front end. Sits between the SPI receive logic and the PE array input buffers.

## Interface
- ADDR_WIDTH, 13, flat word address width; must be ≥ log2(NUM_BANKS)+log2(DATA_DEPTH)
- DATA_WIDTH, 8, word width
- DATA_DEPTH, 1024, words per bank, power of 2
- NUM_BANKS, 4, bank count, power of 2, ≥1
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- csen  in  1  chip select; gates both user ports
- clr_start  in  1  pulse: zero entire memory
- clr_busy  out  1  high while clearing
- ld_start  in  1  pulse: begin streaming load from address 0
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader may transfer
- ld_data  in  DATA_WIDTH  loader word
- ld_done  out  1  one-cycle pulse after last loaded word
- addr_a  in  ADDR_WIDTH  read address
- rdena  in  1  read enable
- data_a  out  DATA_WIDTH  read data
- rd_valid  out  1  data_a carries a real read
- addr_b  in  ADDR_WIDTH  write address
- wrenb  in  1  write enable
- data_b  in  DATA_WIDTH  write data

## Operation
- Address decode: offset = addr[OW-1:0] (OW=log2 DATA_DEPTH); bank = next log2(NUM_BANKS) bits; any higher bit set = out of range.
- FSM states IDLE, CLEAR, LOAD. Reset → IDLE.
- IDLE: port B writes when wrenb&&csen&&in-range; port A reads when rdena&&csen.
- IDLE→CLEAR on clr_start; CLEAR writes 0 at offset counter in all banks in parallel, counter 0..DATA_DEPTH-1, then IDLE.
- IDLE→LOAD on ld_start; ld_ready=1 only in LOAD; each ld_valid&&ld_ready writes ld_data to flat address counter (0..NUM_BANKS*DATA_DEPTH-1, bank-major); after final word: ld_done pulse, IDLE.
- clr_start and ld_start same cycle in IDLE: CLEAR wins, ld_start dropped. Starts outside IDLE ignored.
- During CLEAR/LOAD: port B writes discarded; port A reads return 0 with rd_valid=0.
- Out-of-range write dropped; out-of-range read returns 0 with rd_valid=1.
- Cycle with no qualified read: data_a=0, rd_valid=0.
- Read/write same address same cycle: read returns old data (read-first).
- Memory array has no reset; contents after power-up or reset undefined until CLEAR or LOAD.

## Timing
- Reset values: data_a=0, rd_valid=0, clr_busy=0, ld_ready=0, ld_done=0; counters 0.
- Read latency 1 cycle (rdena sampled at edge N, data_a/rd_valid valid after edge N+1).
- Write visible to a read issued the cycle after the write.
- CLEAR: clr_busy high exactly DATA_DEPTH cycles starting the cycle after clr_start.
- LOAD: ld_ready rises the cycle after ld_start; ld_done pulses the cycle after the last handshake, ld_ready low that same cycle.
- Reset mid-CLEAR/LOAD: immediate IDLE, partially written contents kept.

## Configuration
- MEM_RD_OREG_EN defined: extra output register on data_a/rd_valid, read latency 2, zero-on-idle rule applied at the final stage.
- Undefined: latency 1 as above.

## Structure
- Shared package mem_pkg: FSM state enum, localparams OFFSET_W, BANK_W, TOTAL_WORDS.
- Sub-module mem_bank_dp: one DATA_DEPTH×DATA_WIDTH simple dual-port block-RAM bank, read-first, instantiated NUM_BANKS times; top holds FSM, decode, counters, read mux with registered bank select.

## Test plan
- Reset, then clr_start → clr_busy high 1024 cycles; reads of addr 0, 1023, 4095 return 0, rd_valid=1.
- Write 0xA5 to addr 0x805 (bank 2, offset 5), read next cycle → data_a=0xA5 one cycle later; rdena low → data_a=0.
- Same-cycle write 0x3C/read at addr 7 holding 0x11 → read gives 0x11, following read gives 0x3C.
- ld_start then 4096 words value=addr[7:0] with ld_valid toggling every other cycle → ld_done once after last word; spot reads at 0, 1025, 4095 return 0x00, 0x01, 0xFF.
- Write/read to addr 0x1000 (out of range) → write dropped, read 0 with rd_valid=1; write during CLEAR ignored.
- rst_n asserted mid-LOAD at word 100 → IDLE, ld_ready=0, words 0..99 retained; with MEM_RD_OREG_EN latency measured as 2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the banked feature-map memory.
package mem_pkg;

  localparam int OFFSET_W    = 10;
  localparam int BANK_W      = 2;
  localparam int TOTAL_WORDS = 1 << (OFFSET_W + BANK_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } fsm_state_e;

  // Index bits needed to select one of n items; a single item needs none.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/mem_bank_dp.sv
// One simple dual-port RAM bank: synchronous write port, registered read-first read port.
module mem_bank_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];

  // Array write and read-first registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      q <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/fmap_bank_mem.sv
// Banked feature-map memory with hardware clear and streaming loader.
// Define MEM_RD_OREG_EN to add an output register on the read port (latency 2).
module fmap_bank_mem
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1 << OFFSET_W,
  parameter int NUM_BANKS  = 1 << BANK_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csen,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_done,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  rdena,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  wrenb,
  input  logic [DATA_WIDTH-1:0] data_b
);

  localparam int OW     = bits_for(DATA_DEPTH);
  localparam int BW     = bits_for(NUM_BANKS);
  localparam int CW     = OW + BW;
  localparam int NWORDS = NUM_BANKS * DATA_DEPTH;

  fsm_state_e            state_r;
  logic [CW-1:0]         cnt_r;
  logic                  ld_done_r;
  logic [NUM_BANKS-1:0]  bank_we_s;
  logic [NUM_BANKS-1:0]  rd_en_s;
  logic [NUM_BANKS-1:0]  rd_sel_r;
  logic [OW-1:0]         bank_waddr_s;
  logic [DATA_WIDTH-1:0] bank_wdata_s;
  logic [DATA_WIDTH-1:0] rd_mux_s;
  logic [DATA_WIDTH-1:0] bank_q_s [NUM_BANKS];
  logic                  rd_valid_r;
  logic                  in_range_a_s;
  logic                  in_range_b_s;
  logic                  rd_qual_s;

  assign in_range_a_s = ((addr_a >> CW) == '0);
  assign in_range_b_s = ((addr_b >> CW) == '0);
  assign rd_qual_s    = (state_r == ST_IDLE) && rdena && csen;
  assign clr_busy     = (state_r == ST_CLEAR);
  assign ld_ready     = (state_r == ST_LOAD);
  assign ld_done      = ld_done_r;

  // Sequencer: clear walks offsets across all banks, load walks the flat space bank-major
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      ld_done_r <= 1'b0;
    end else begin
      ld_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (clr_start) begin
            state_r <= ST_CLEAR;
          end else if (ld_start) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (cnt_r == CW'(DATA_DEPTH - 1)) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            if (cnt_r == CW'(NWORDS - 1)) begin
              state_r   <= ST_IDLE;
              cnt_r     <= '0;
              ld_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Write-port steering: user port in IDLE, sequencers otherwise
  always_comb begin
    bank_we_s    = '0;
    bank_waddr_s = addr_b[OW-1:0];
    bank_wdata_s = data_b;
    case (state_r)
      ST_IDLE: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          bank_we_s[b] = wrenb && csen && in_range_b_s &&
                         ((addr_b >> OW) == ADDR_WIDTH'(b));
        end
      end
      ST_CLEAR: begin
        bank_we_s    = '1;
        bank_waddr_s = cnt_r[OW-1:0];
        bank_wdata_s = '0;
      end
      ST_LOAD: begin
        bank_waddr_s = cnt_r[OW-1:0];
        bank_wdata_s = ld_data;
        for (int b = 0; b < NUM_BANKS; b++) begin
          bank_we_s[b] = ld_valid && ((cnt_r >> OW) == CW'(b));
        end
      end
      default: begin
        bank_we_s = '0;
      end
    endcase
  end

  // Read enables per bank; out-of-range reads enable no bank and so return 0
  always_comb begin
    rd_en_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_en_s[b] = rd_qual_s && in_range_a_s && ((addr_a >> OW) == ADDR_WIDTH'(b));
    end
  end

  // Registered bank select and read-valid, aligned with bank output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_r   <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_sel_r   <= rd_en_s;
      rd_valid_r <= rd_qual_s;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank_dp #(
      .DATA_WIDTH(DATA_WIDTH),
      .DATA_DEPTH(DATA_DEPTH),
      .AW        (OW)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we_s[g]),
      .waddr(bank_waddr_s),
      .wdata(bank_wdata_s),
      .re   (rd_en_s[g]),
      .raddr(addr_a[OW-1:0]),
      .q    (bank_q_s[g])
    );
  end

  // One-hot AND-OR mux; an empty select forces the zero-on-idle value
  always_comb begin
    rd_mux_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_mux_s = rd_mux_s | (bank_q_s[b] & {DATA_WIDTH{rd_sel_r[b]}});
    end
  end

`ifdef MEM_RD_OREG_EN
  logic [DATA_WIDTH-1:0] data_a_r;
  logic                  rd_valid_o_r;

  // Optional output stage for timing closure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_r     <= '0;
      rd_valid_o_r <= 1'b0;
    end else begin
      data_a_r     <= rd_mux_s;
      rd_valid_o_r <= rd_valid_r;
    end
  end

  assign data_a   = data_a_r;
  assign rd_valid = rd_valid_o_r;
`else
  assign data_a   = rd_mux_s;
  assign rd_valid = rd_valid_r;
`endif

endmodule

// File: tb/tb_fmap_bank_mem.sv
// Self-checking bench for fmap_bank_mem: flat-array reference model plus directed vectors.
module tb_fmap_bank_mem;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int NB    = 4;
  localparam int TOTAL = DEPTH * NB;
`ifdef MEM_RD_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_LOAD  = 2;

  logic          clk, rst_n, csen, clr_start, clr_busy, ld_start, ld_valid, ld_ready, ld_done;
  logic [DW-1:0] ld_data, data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          rdena, rd_valid, wrenb;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  fmap_bank_mem dut (
    .clk(clk), .rst_n(rst_n), .csen(csen),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_done(ld_done),
    .addr_a(addr_a), .rdena(rdena), .data_a(data_a), .rd_valid(rd_valid),
    .addr_b(addr_b), .wrenb(wrenb), .data_b(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: flat word array, -1 marks never-written contents
  int mem_m [TOTAL];
  int mode_m, cnt_m, ed1, ed2, edone;
  bit ev1, ev2;

  initial for (int i = 0; i < TOTAL; i++) mem_m[i] = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_m <= M_IDLE; cnt_m <= 0; edone <= 0;
      ev1 <= 1'b0; ed1 <= 0; ev2 <= 1'b0; ed2 <= 0;
    end else begin
      if (mode_m == M_IDLE && rdena && csen) begin
        ev1 <= 1'b1;
        ed1 <= (int'(addr_a) < TOTAL) ? mem_m[addr_a] : 0;
      end else begin
        ev1 <= 1'b0; ed1 <= 0;
      end
      ev2 <= ev1; ed2 <= ed1;
      edone <= 0;
      case (mode_m)
        M_IDLE: begin
          if (wrenb && csen && int'(addr_b) < TOTAL) mem_m[addr_b] <= int'(data_b);
          cnt_m <= 0;
          if (clr_start) mode_m <= M_CLEAR;
          else if (ld_start) mode_m <= M_LOAD;
        end
        M_CLEAR: begin
          for (int i = 0; i < TOTAL; i++) if (i % DEPTH == cnt_m) mem_m[i] <= 0;
          if (cnt_m == DEPTH - 1) mode_m <= M_IDLE;
          else cnt_m <= cnt_m + 1;
        end
        default: begin
          if (ld_valid) begin
            mem_m[cnt_m] <= int'(ld_data);
            if (cnt_m == TOTAL - 1) begin mode_m <= M_IDLE; edone <= 1; end
            else cnt_m <= cnt_m + 1;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      int ed;
      bit ev;
      ed = (LAT == 2) ? ed2 : ed1;
      ev = (LAT == 2) ? ev2 : ev1;
      chk("rd_valid", int'(rd_valid), int'(ev));
      if (ed >= 0) chk("data_a", int'(data_a), ed);
      chk("clr_busy", int'(clr_busy), int'(mode_m == M_CLEAR));
      chk("ld_ready", int'(ld_ready), int'(mode_m == M_LOAD));
      chk("ld_done", int'(ld_done), edone);
      if (ld_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    addr_b = AW'(a); data_b = DW'(d); wrenb = 1'b1; csen = 1'b1;
    tick();
    wrenb = 1'b0;
  endtask

  task automatic read_word(input int a, output int d, output int v);
    addr_a = AW'(a); rdena = 1'b1; csen = 1'b1;
    tick();
    rdena = 1'b0;
    if (LAT == 2) tick();
    d = int'(data_a); v = int'(rd_valid);
  endtask

  task automatic run_clear(input bit poke);
    int n;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 5000) begin
      if (poke && n == 500) begin addr_b = 13'd10; data_b = 8'h77; wrenb = 1'b1; end
      else wrenb = 1'b0;
      n++;
      tick();
    end
    wrenb = 1'b0;
    chk("clr_busy_cycles", n, DEPTH);
  endtask

  initial begin
    int d, v, n;
    rst_n = 1'b0; csen = 1'b0; clr_start = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_data = '0; addr_a = '0; addr_b = '0; rdena = 1'b0; wrenb = 1'b0; data_b = '0;
    #12;
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_ld_done", int'(ld_done), 0);
    #10 rst_n = 1'b1;
    tick();

    // Clear, with a write attempted mid-clear after offset 10 was zeroed
    run_clear(1'b1);
    read_word(0, d, v);    chk("clr_rd0", d, 0);    chk("clr_rd0_v", v, 1);
    read_word(1023, d, v); chk("clr_rd1023", d, 0); chk("clr_rd1023_v", v, 1);
    read_word(4095, d, v); chk("clr_rd4095", d, 0); chk("clr_rd4095_v", v, 1);
    read_word(10, d, v);   chk("wr_during_clr", d, 0);

    // Basic write then read; then an idle cycle must show zero
    write_word(13'h805, 8'hA5);
    read_word(13'h805, d, v); chk("rd_805", d, 8'hA5); chk("rd_805_v", v, 1);
    tick();
    chk("idle_data_a", int'(data_a), 0);
    chk("idle_rd_valid", int'(rd_valid), 0);

    // Same-cycle read/write returns old data
    write_word(7, 8'h11);
    addr_b = 13'd7; data_b = 8'h3C; wrenb = 1'b1; addr_a = 13'd7; rdena = 1'b1;
    tick();
    wrenb = 1'b0; rdena = 1'b0;
    if (LAT == 2) tick();
    chk("rw_same_old", int'(data_a), 8'h11);
    read_word(7, d, v); chk("rw_same_new", d, 8'h3C);

    // Out-of-range access
    write_word(13'h1000, 8'h5A);
    read_word(13'h1000, d, v); chk("oor_rd", d, 0); chk("oor_rd_v", v, 1);
    read_word(0, d, v); chk("oor_no_alias", d, 0);

    // Full streaming load with ld_valid toggling
    done_cnt = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int w = 0; w < TOTAL; w++) begin
      ld_valid = 1'b0; tick();
      ld_valid = 1'b1; ld_data = w[7:0]; tick();
    end
    ld_valid = 1'b0;
    chk("ld_done_pulse", int'(ld_done), 1);
    chk("ld_ready_low_at_done", int'(ld_ready), 0);
    tick(); tick();
    chk("ld_done_count", done_cnt, 1);
    read_word(0, d, v);    chk("ld_rd0", d, 8'h00);
    read_word(1025, d, v); chk("ld_rd1025", d, 8'h01);
    read_word(4095, d, v); chk("ld_rd4095", d, 8'hFF);

    // Read latency measurement
    addr_a = 13'd1025; rdena = 1'b1; tick(); rdena = 1'b0;
    n = 1;
    while (!rd_valid && n < 10) begin tick(); n++; end
    chk("rd_latency", n, LAT);
    tick(); tick();

    // Reset in the middle of a load after 100 words
    run_clear(1'b0);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int w = 0; w < 100; w++) begin
      ld_valid = 1'b1; ld_data = w[7:0]; tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midld_rst_ld_ready", int'(ld_ready), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("midld_ld_ready_after", int'(ld_ready), 0);
    read_word(0, d, v);   chk("midld_rd0", d, 0);
    read_word(99, d, v);  chk("midld_rd99", d, 99);
    read_word(100, d, v); chk("midld_rd100", d, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, n_pass=%0d", n_pass);
    $fatal(1);
  end

endmodule
